// File: rtl/add_seq_ctrl.sv
// rtl/add_seq_ctrl.sv - command-driven sequencer for the 8-bit accumulate datapath
module add_seq_ctrl #(
    parameter int W            = 8,
    parameter int N_W          = 8,
    parameter int DEFAULT_STEP = 2
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           cmd_valid,
    output logic           cmd_ready,
    input  logic [1:0]     cmd_op,
    input  logic [W-1:0]   cmd_data,
    input  logic           hold,
    input  logic           abort,
    output logic [W-1:0]   dp_a,
    output logic [W-1:0]   dp_b,
    output logic [W-1:0]   dp_step,
    output logic           cnt_clr,
    output logic           cnt_en,
    output logic           busy,
    output logic           done,
    output logic [N_W-1:0] remaining
);

    localparam logic [1:0] OP_LOAD_A   = 2'd0;
    localparam logic [1:0] OP_LOAD_B   = 2'd1;
    localparam logic [1:0] OP_SET_STEP = 2'd2;
    localparam logic [1:0] OP_RUN      = 2'd3;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_CLEAR = 2'd1,
        S_RUN   = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t         state;
    logic [N_W-1:0] run_len;

    assign run_len = cmd_data[N_W-1:0];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            dp_a      <= '0;
            dp_b      <= '0;
            dp_step   <= W'(DEFAULT_STEP);
            remaining <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (cmd_valid) begin
                        case (cmd_op)
                            OP_LOAD_A:   dp_a    <= cmd_data;
                            OP_LOAD_B:   dp_b    <= cmd_data;
                            OP_SET_STEP: dp_step <= cmd_data;
                            OP_RUN: begin
                                if (run_len == '0) begin
                                    state <= S_DONE;
                                end else begin
                                    remaining <= run_len;
                                    state     <= S_CLEAR;
                                end
                            end
                            default: ;
                        endcase
                    end
                end
                S_CLEAR: begin
                    if (abort) begin
                        remaining <= '0;
                        state     <= S_IDLE;
                    end else begin
                        state <= S_RUN;
                    end
                end
                S_RUN: begin
                    // abort outranks both hold and the final advance
                    if (abort) begin
                        remaining <= '0;
                        state     <= S_IDLE;
                    end else if (!hold) begin
                        if (remaining <= N_W'(1)) begin
                            remaining <= '0;
                            state     <= S_DONE;
                        end else begin
                            remaining <= remaining - N_W'(1);
                        end
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    // Status strobes decode straight from the state register; only the advance
    // enable looks at hold/abort so a paused or cancelled cycle never advances.
    assign cmd_ready = (state == S_IDLE);
    assign busy      = (state == S_CLEAR) || (state == S_RUN);
    assign cnt_clr   = (state == S_CLEAR);
    assign done      = (state == S_DONE);
    assign cnt_en    = (state == S_RUN) && !hold && !abort;

endmodule

// File: tb/tb_add_seq_ctrl.sv
// tb/tb_add_seq_ctrl.sv - scoreboard bench for add_seq_ctrl
module tb_add_seq_ctrl;

    localparam int KIND_CLR  = 0;
    localparam int KIND_EN   = 1;
    localparam int KIND_DONE = 2;
    localparam int KIND_NONE = 3;

    logic       clk;
    logic       rst_n;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [1:0] cmd_op;
    logic [7:0] cmd_data;
    logic       hold;
    logic       abort;
    logic [7:0] dp_a;
    logic [7:0] dp_b;
    logic [7:0] dp_step;
    logic       cnt_clr;
    logic       cnt_en;
    logic       busy;
    logic       done;
    logic [7:0] remaining;

    typedef struct {
        int kind;
        int rem;
        int cyc;
    } evt_t;

    evt_t q[$];
    int   n_checks = 0;
    int   n_errors = 0;
    int   cyc = 0;
    logic [7:0] exp_a, exp_b, exp_step;

    add_seq_ctrl #(.W(8), .N_W(8), .DEFAULT_STEP(2)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_data  (cmd_data),
        .hold      (hold),
        .abort     (abort),
        .dp_a      (dp_a),
        .dp_b      (dp_b),
        .dp_step   (dp_step),
        .cnt_clr   (cnt_clr),
        .cnt_en    (cnt_en),
        .busy      (busy),
        .done      (done),
        .remaining (remaining)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic push(input int kind, input int rem, input int c);
        evt_t e;
        e.kind = kind;
        e.rem  = rem;
        e.cyc  = c;
        q.push_back(e);
    endtask

    // Monitor: every strobe cycle must match the head of the scoreboard.
    always @(negedge clk) begin
        int   kind;
        evt_t e;
        if (cnt_clr === 1'b1 && cnt_en === 1'b1)
            chk("clr_en_overlap", 1, 0);
        if (cnt_clr === 1'b1 || cnt_en === 1'b1 || done === 1'b1) begin
            kind = (cnt_clr === 1'b1) ? KIND_CLR : (cnt_en === 1'b1) ? KIND_EN : KIND_DONE;
            if (q.size() == 0) begin
                chk("unexpected_evt", kind, KIND_NONE);
            end else begin
                e = q.pop_front();
                chk("evt_kind", kind, e.kind);
                chk("evt_cycle", cyc, e.cyc);
                chk("evt_rem", {24'd0, remaining}, e.rem);
                chk("evt_busy", {31'd0, busy}, (e.kind == KIND_DONE) ? 0 : 1);
                if (kind == KIND_EN) begin
                    chk("run_dp_a", {24'd0, dp_a}, {24'd0, exp_a});
                    chk("run_dp_b", {24'd0, dp_b}, {24'd0, exp_b});
                    chk("run_dp_step", {24'd0, dp_step}, {24'd0, exp_step});
                end
                if (kind == KIND_DONE)
                    chk("done_ready", {31'd0, cmd_ready}, 0);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [1:0] op, input logic [7:0] data,
                        output int acc_cyc, output int waited);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_data  = data;
        waited    = 0;
        while (cmd_ready !== 1'b1 && waited < 50) begin
            step();
            waited++;
        end
        if (cmd_ready !== 1'b1) begin
            chk("send_timeout", 0, 1);
            cmd_valid = 1'b0;
            acc_cyc   = -1;
        end else begin
            step();
            cmd_valid = 1'b0;
            acc_cyc   = cyc;
        end
    endtask

    task automatic drain();
        int n = 0;
        while (q.size() != 0 && n < 100) begin
            step();
            n++;
        end
        chk("drain_timeout", q.size(), 0);
        step();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not end in time");
        $fatal(1);
    end

    initial begin
        int a, w;
        rst_n     = 1'b0;
        cmd_valid = 1'b0;
        cmd_op    = 2'd0;
        cmd_data  = 8'd0;
        hold      = 1'b0;
        abort     = 1'b0;
        exp_a     = 8'h00;
        exp_b     = 8'h00;
        exp_step  = 8'h02;
        repeat (2) step();

        chk("rst_dp_a", {24'd0, dp_a}, 0);
        chk("rst_dp_b", {24'd0, dp_b}, 0);
        chk("rst_dp_step", {24'd0, dp_step}, 2);
        chk("rst_remaining", {24'd0, remaining}, 0);
        chk("rst_busy", {31'd0, busy}, 0);
        chk("rst_done", {31'd0, done}, 0);
        chk("rst_ready", {31'd0, cmd_ready}, 1);
        chk("rst_cnt_en", {31'd0, cnt_en}, 0);
        rst_n = 1'b1;
        step();

        // configure then run 4
        send(2'd0, 8'h10, a, w);
        send(2'd1, 8'h05, a, w);
        send(2'd2, 8'h03, a, w);
        exp_a = 8'h10; exp_b = 8'h05; exp_step = 8'h03;
        chk("cfg_dp_a", {24'd0, dp_a}, 32'h10);
        chk("cfg_dp_b", {24'd0, dp_b}, 32'h05);
        chk("cfg_dp_step", {24'd0, dp_step}, 32'h03);
        send(2'd3, 8'd4, a, w);
        push(KIND_CLR, 4, a);
        for (int i = 0; i < 4; i++) push(KIND_EN, 4 - i, a + 1 + i);
        push(KIND_DONE, 0, a + 5);
        drain();
        chk("run4_idle_ready", {31'd0, cmd_ready}, 1);
        chk("run4_dp_a_kept", {24'd0, dp_a}, 32'h10);

        // hold on the second RUN cycle
        send(2'd3, 8'd3, a, w);
        push(KIND_CLR, 3, a);
        push(KIND_EN, 3, a + 1);
        push(KIND_EN, 2, a + 3);
        push(KIND_EN, 1, a + 4);
        push(KIND_DONE, 0, a + 5);
        step();
        step();
        hold = 1'b1;
        @(negedge clk);
        chk("hold_cnt_en", {31'd0, cnt_en}, 0);
        chk("hold_remaining", {24'd0, remaining}, 2);
        chk("hold_busy", {31'd0, busy}, 1);
        step();
        hold = 1'b0;
        drain();

        // abort on the third RUN cycle
        send(2'd3, 8'd10, a, w);
        push(KIND_CLR, 10, a);
        push(KIND_EN, 10, a + 1);
        push(KIND_EN, 9, a + 2);
        repeat (3) step();
        abort = 1'b1;
        @(negedge clk);
        chk("abort_cnt_en", {31'd0, cnt_en}, 0);
        step();
        abort = 1'b0;
        chk("abort_remaining", {24'd0, remaining}, 0);
        chk("abort_busy", {31'd0, busy}, 0);
        chk("abort_ready", {31'd0, cmd_ready}, 1);
        chk("abort_queue", q.size(), 0);
        send(2'd0, 8'h7F, a, w);
        exp_a = 8'h7F;
        chk("abort_load_wait", w, 0);
        chk("abort_load_a", {24'd0, dp_a}, 32'h7F);

        // zero-length run
        send(2'd3, 8'd0, a, w);
        push(KIND_DONE, 0, a);
        drain();

        // back-pressure during RUN 2
        send(2'd3, 8'd2, a, w);
        push(KIND_CLR, 2, a);
        push(KIND_EN, 2, a + 1);
        push(KIND_EN, 1, a + 2);
        push(KIND_DONE, 0, a + 3);
        chk("bp_ready_low", {31'd0, cmd_ready}, 0);
        chk("bp_dp_b_held", {24'd0, dp_b}, 32'h05);
        send(2'd1, 8'hAA, a, w);
        exp_b = 8'hAA;
        chk("bp_wait_cycles", w, 4);
        chk("bp_dp_b_new", {24'd0, dp_b}, 32'hAA);
        chk("bp_queue", q.size(), 0);

        // reset mid-run while remaining = 5
        send(2'd3, 8'd8, a, w);
        push(KIND_CLR, 8, a);
        for (int i = 0; i < 4; i++) push(KIND_EN, 8 - i, a + 1 + i);
        repeat (4) step();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        @(negedge clk);
        chk("mrst_remaining", {24'd0, remaining}, 0);
        chk("mrst_dp_step", {24'd0, dp_step}, 2);
        chk("mrst_dp_a", {24'd0, dp_a}, 0);
        chk("mrst_cnt_en", {31'd0, cnt_en}, 0);
        chk("mrst_busy", {31'd0, busy}, 0);
        chk("mrst_ready", {31'd0, cmd_ready}, 1);
        repeat (4) step();
        chk("mrst_queue", q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/add_seq_ctrl.md
Name: add_seq_ctrl

Overview:
Command-driven sequencer for the 8-bit accumulate datapath. That datapath sums operand A, operand B and a stepped counter into the registered output byte.
- Captures operands and counter step from a narrow byte-wide command bus.
- Issues a counter-clear, then runs the datapath for a programmed number of cycles and signals completion.
- Sits between the pin-level input decode and the adder/counter datapath in the top-level wrapper.

Parameters:
W, 8, datapath width of operands A/B and counter step
N_W, 8, width of run-length field and remaining-cycle counter
DEFAULT_STEP, 2, reset value of the counter step register

Ports:
clk  in  1  clock
rst_n  in  1  reset, synchronous, active-low
cmd_valid  in  1  command present
cmd_ready  out  1  controller accepts a command this cycle
cmd_op  in  2  0=LOAD_A, 1=LOAD_B, 2=SET_STEP, 3=RUN
cmd_data  in  W  operand / step / run length (RUN uses low N_W bits)
hold  in  1  pause an active run
abort  in  1  cancel an active run
dp_a  out  W  operand A to datapath
dp_b  out  W  operand B to datapath
dp_step  out  W  counter increment to datapath
cnt_clr  out  1  datapath counter/output clear strobe
cnt_en  out  1  datapath advance enable (output update + counter += step)
busy  out  1  run in progress
done  out  1  one-cycle completion pulse
remaining  out  N_W  cycles left in current run

Behaviour:
- Clock and reset:
  - Single clock clk. rst_n is sampled on posedge clk; low forces reset regardless of state, including mid-run.
- Reset values:
  - state=IDLE.
  - dp_a=0, dp_b=0, dp_step=DEFAULT_STEP, remaining=0.
  - cnt_clr=0, cnt_en=0, busy=0, done=0, cmd_ready=1.
  - Reset during a run emits no done pulse.
- Handshake:
  - A command is accepted on a cycle with cmd_valid=1 and cmd_ready=1.
  - cmd_ready=1 only in IDLE. Commands presented in any other state are not accepted and have no effect; the source holds them.
- State machine (Moore outputs): IDLE, CLEAR, RUN, DONE.
  - IDLE:
    - LOAD_A: dp_a<=cmd_data. LOAD_B: dp_b<=cmd_data. SET_STEP: dp_step<=cmd_data. New values are visible the next cycle; state stays IDLE.
    - RUN with cmd_data==0: next state DONE; no cnt_clr, no cnt_en.
    - RUN with cmd_data!=0: remaining<=cmd_data[N_W-1:0]; next state CLEAR.
  - CLEAR:
    - cnt_clr=1, busy=1. Exactly one cycle, then RUN.
  - RUN:
    - busy=1. cnt_en=1 when hold=0; on that edge remaining decrements.
    - When remaining==1 and hold=0, next state DONE and remaining<=0.
    - hold=1: cnt_en=0, remaining unchanged, stay in RUN.
  - DONE:
    - done=1, busy=0, cmd_ready=0. One cycle, then IDLE.
- Abort:
  - abort=1 in CLEAR or RUN: next state IDLE, remaining<=0, no done pulse, cnt_en=0 that cycle. Abort has priority over hold and over normal completion.
  - abort is ignored in IDLE and DONE.
- Run length and arithmetic:
  - A run produces exactly N cnt_en cycles, N = RUN data (1..2^N_W-1).
  - remaining never underflows.
  - dp_* registers are not modified by a run. The datapath wraps modulo 2^W, which is not this block's concern.
- cnt_clr and cnt_en are never asserted in the same cycle.

Test Plan:
- Reset: hold rst_n=0 two cycles -> dp_a=0, dp_b=0, dp_step=2, remaining=0, busy=0, done=0, cmd_ready=1, cnt_en=0.
- Configure then run: LOAD_A 0x10, LOAD_B 0x05, SET_STEP 0x03, RUN 4 accepted at cycle t.
  - Required: cnt_clr=1 at t+1; cnt_en=1 at t+2..t+5 with remaining 4,3,2,1; done=1 at t+6; IDLE at t+7.
  - Registers stay 0x10/0x05/0x03 throughout.
- Hold mid-run: RUN 3 with hold=1 on the second RUN cycle -> exactly 3 cnt_en pulses over 4 RUN cycles; remaining stays 2 during the hold cycle; done one cycle after the last cnt_en.
- Abort mid-run: RUN 10, abort=1 on the 3rd RUN cycle (hold=0).
  - Required: 2 cnt_en pulses, then IDLE next cycle; remaining=0; done never asserts; a following LOAD_A 0x7F is accepted.
- Zero-length and back-pressure: RUN 0 -> done=1 next cycle, no cnt_clr/cnt_en.
  - During RUN 2, present LOAD_B 0xAA -> cmd_ready=0, dp_b unchanged until DONE→IDLE, then accepted.
- Reset mid-run: rst_n=0 during RUN (remaining=5) -> next cycle IDLE, remaining=0, dp_step=2, cnt_en=0, no done pulse.
